// File: rtl/idwt_row_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module      : idwt_row_pair_feeder
// Description : Buffers the approximation half of a tile, then pairs each
//               detail row with its approximation row for the IDWT column
//               stage. Optional macro IDWT_FEED_HOLD_EN: hold last pair
//               while idle (otherwise idle outputs are 0).
// Revision    : 1.0 - initial release
// ============================================================================
module idwt_row_pair_feeder #(
    parameter int DATA_W    = 64,
    parameter int HALF_ROWS = 4,
    parameter int IDX_W     = $clog2(HALF_ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tile_restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] pixel_out1,
    output logic [DATA_W-1:0] pixel_out2,
    output logic              out_valid,
    output logic [IDX_W-1:0]  out_row_idx,
    output logic              tile_done,
    output logic [15:0]       tile_count,
    output logic              busy
);

`ifdef IDWT_FEED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_PAIR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  buf_q [HALF_ROWS];

    logic [DATA_W-1:0]  pix1_q, pix2_q;
    logic [IDX_W-1:0]   idx_q;
    logic               valid_q;
    logic               done_q;
    logic [15:0]        tile_count_q;

    logic               w_accept;
    logic               w_last;
    logic               w_pair_fire;

    assign in_ready    = ~tile_restart;
    assign w_accept    = in_valid & in_ready;
    assign w_last      = (cnt_q == IDX_W'(HALF_ROWS - 1));
    assign w_pair_fire = w_accept & (state_q == S_PAIR);

    // cnt wraps to 0 on its own at HALF_ROWS-1 because HALF_ROWS is a power of two
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tile_restart) begin
            state_d = S_FILL;
            cnt_d   = '0;
        end else if (w_accept) begin
            cnt_d = cnt_q + 1'b1;
            if (w_last) begin
                state_d = (state_q == S_FILL) ? S_PAIR : S_FILL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data-only storage: no reset, stale rows are always overwritten before use
    always_ff @(posedge clk) begin
        if (w_accept && (state_q == S_FILL)) begin
            buf_q[cnt_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix1_q       <= '0;
            pix2_q       <= '0;
            idx_q        <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            tile_count_q <= '0;
        end else begin
            valid_q <= w_pair_fire;
            done_q  <= w_pair_fire & w_last;
            if (w_pair_fire) begin
                pix1_q <= buf_q[cnt_q];
                pix2_q <= in_data;
                idx_q  <= cnt_q;
                if (w_last) begin
                    tile_count_q <= tile_count_q + 16'd1;
                end
            end else if (!HOLD_EN) begin
                pix1_q <= '0;
                pix2_q <= '0;
                idx_q  <= '0;
            end
        end
    end

    assign pixel_out1  = pix1_q;
    assign pixel_out2  = pix2_q;
    assign out_row_idx = idx_q;
    assign out_valid   = valid_q;
    assign tile_done   = done_q;
    assign tile_count  = tile_count_q;
    assign busy        = (state_q == S_PAIR);

endmodule
`default_nettype wire

// File: tb/tb_idwt_row_pair_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_idwt_row_pair_feeder
// Description : Directed self-checking bench for idwt_row_pair_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idwt_row_pair_feeder;

    localparam int DATA_W    = 64;
    localparam int HALF_ROWS = 4;
    localparam int IDX_W     = 2;

`ifdef IDWT_FEED_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              tile_restart;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] pixel_out1;
    logic [DATA_W-1:0] pixel_out2;
    logic              out_valid;
    logic [IDX_W-1:0]  out_row_idx;
    logic              tile_done;
    logic [15:0]       tile_count;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_cnt = 16'd0;

    idwt_row_pair_feeder #(
        .DATA_W    (DATA_W),
        .HALF_ROWS (HALF_ROWS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tile_restart (tile_restart),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .pixel_out1   (pixel_out1),
        .pixel_out2   (pixel_out2),
        .out_valid    (out_valid),
        .out_row_idx  (out_row_idx),
        .tile_done    (tile_done),
        .tile_count   (tile_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Rows are scaled by k+1 so no row is all-zero and stays distinguishable from idle output
    function automatic logic [63:0] a_row(input int k);
        return 64'h0101010101010101 * 64'(k + 1);
    endfunction

    function automatic logic [63:0] d_row(input int k);
        return 64'h1010101010101010 * 64'(k + 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int last_k);
        check_val("idle_valid", 64'(out_valid), 64'd0);
        check_val("idle_done",  64'(tile_done), 64'd0);
        check_val("idle_pix1",  pixel_out1, HOLD_EN ? a_row(last_k) : 64'd0);
        check_val("idle_pix2",  pixel_out2, HOLD_EN ? d_row(last_k) : 64'd0);
        check_val("idle_idx",   64'(out_row_idx), HOLD_EN ? 64'(last_k) : 64'd0);
    endtask

    task automatic run_tile(input bit gaps);
        for (int i = 0; i < 2 * HALF_ROWS; i++) begin
            in_valid = 1'b1;
            in_data  = (i < HALF_ROWS) ? a_row(i) : d_row(i - HALF_ROWS);
            tick();
            if (i >= HALF_ROWS) begin
                check_val("pair_valid", 64'(out_valid), 64'd1);
                check_val("pair_pix1",  pixel_out1, a_row(i - HALF_ROWS));
                check_val("pair_pix2",  pixel_out2, d_row(i - HALF_ROWS));
                check_val("pair_idx",   64'(out_row_idx), 64'(i - HALF_ROWS));
                check_val("pair_done",  64'(tile_done), 64'(i == 2 * HALF_ROWS - 1));
            end else begin
                check_val("fill_valid", 64'(out_valid), 64'd0);
            end
            check_val("busy", 64'(busy), 64'((i >= HALF_ROWS - 1) && (i < 2 * HALF_ROWS - 1)));
            if (gaps) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                tick();
                check_val("gap_valid", 64'(out_valid), 64'd0);
                if (i >= HALF_ROWS) idle_check(i - HALF_ROWS);
            end
        end
        exp_cnt = exp_cnt + 16'd1;
        check_val("tile_count", 64'(tile_count), 64'(exp_cnt));
        in_valid = 1'b0;
        tick();
        idle_check(HALF_ROWS - 1);
        check_val("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic send(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    initial begin
        rst_n        = 1'b0;
        tile_restart = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        #12;
        // reset state
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_ready", 64'(in_ready), 64'd1);
        check_val("rst_busy",  64'(busy), 64'd0);
        check_val("rst_count", 64'(tile_count), 64'd0);
        check_val("rst_pix1",  pixel_out1, 64'd0);
        rst_n = 1'b1;
        tick();

        // T1: continuous stream
        run_tile(1'b0);
        // back-to-back tile, then T2 with in_valid toggling
        run_tile(1'b0);
        run_tile(1'b1);

        // T3: abort during fill (three rows), then clean tile
        send(a_row(0));
        send(a_row(1));
        send(d_row(0));
        in_valid     = 1'b0;
        tile_restart = 1'b1;
        tick();
        tile_restart = 1'b0;
        check_val("abort_valid", 64'(out_valid), 64'd0);
        check_val("abort_busy",  64'(busy), 64'd0);
        run_tile(1'b0);

        // abort mid-pair: one pair already emitted, count must not move
        for (int k = 0; k < HALF_ROWS; k++) send(a_row(k));
        send(d_row(0));
        check_val("midpair_valid", 64'(out_valid), 64'd1);
        // T4: restart together with valid data
        in_valid     = 1'b1;
        in_data      = 64'hDEADBEEFCAFEF00D;
        tile_restart = 1'b1;
        #1;
        check_val("restart_ready", 64'(in_ready), 64'd0);
        tick();
        tile_restart = 1'b0;
        in_valid     = 1'b0;
        check_val("restart_valid", 64'(out_valid), 64'd0);
        check_val("restart_done",  64'(tile_done), 64'd0);
        check_val("restart_busy",  64'(busy), 64'd0);
        check_val("restart_count", 64'(tile_count), 64'(exp_cnt));
        run_tile(1'b0);

        // T5: asynchronous reset during S_PAIR
        for (int k = 0; k < HALF_ROWS; k++) send(a_row(k));
        send(d_row(0));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 64'(out_valid), 64'd0);
        check_val("arst_pix1",  pixel_out1, 64'd0);
        check_val("arst_pix2",  pixel_out2, 64'd0);
        check_val("arst_busy",  64'(busy), 64'd0);
        check_val("arst_count", 64'(tile_count), 64'd0);
        check_val("arst_ready", 64'(in_ready), 64'd1);
        exp_cnt = 16'd0;
        tick();
        rst_n = 1'b1;
        tick();
        run_tile(1'b0);

        // T6: tile_count wrap
        force dut.tile_count_q = 16'hFFFF;
        #1;
        release dut.tile_count_q;
        tick();
        check_val("forced_count", 64'(tile_count), 64'hFFFF);
        exp_cnt = 16'hFFFF;
        run_tile(1'b0);
        check_val("wrap_count", 64'(tile_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
